// File: rtl/csoc_dbg_pkg.sv
// Shared definitions for the CSoC debug path: sequencer state encoding,
// ASCII characters streamed to the UART, and default chain geometry.
package csoc_dbg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOC_RST,
        ST_RUN_HI,
        ST_RUN_LO,
        ST_SEND,
        ST_WAIT,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_EOL,
        ST_EOL_WAIT,
        ST_DONE
    } state_t;

    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_NL = 8'h0A;

    localparam int DEF_CHAIN_LEN = 1919;
    localparam int DEF_MAX_COL   = 8;
    localparam int DEF_RST_TICKS = 4;

    function automatic logic [7:0] scan_char(input logic b);
        return b ? CH_H : CH_L;
    endfunction

endpackage

// File: rtl/uart_tx_req.sv
// Byte request holder for the UART transmitter.
// Ports:
//   clk, rstn        system clock, synchronous active-low reset
//   i_load, i_data   load a byte (ignored while a byte is still pending)
//   i_clear          drop any pending request
//   tx_ready_i       transmitter idle
//   tx_start_o       registered byte request
//   tx_data_o        registered byte
//   o_accept         pulse in the cycle the transmitter takes the byte
module uart_tx_req (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_clear,
    input  logic       tx_ready_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       o_accept
);
    logic       r_start;
    logic [7:0] r_data;

    assign o_accept   = r_start & tx_ready_i;
    assign tx_start_o = r_start;
    assign tx_data_o  = r_data;

    // A load is only taken while no request is outstanding, so after an
    // acceptance the request line is guaranteed low for at least one cycle
    // (the transmitter drops tx_ready_i the cycle after it takes a byte).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_start <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_clear) begin
            r_start <= 1'b0;
        end else if (r_start) begin
            if (tx_ready_i) r_start <= 1'b0;
        end else if (i_load) begin
            r_start <= 1'b1;
            r_data  <= i_data;
        end
    end

endmodule

// File: rtl/scan_dump_ctrl.sv
// Runs the CSoC for a programmable number of functional clocks, then shifts
// its scan chain out one bit per CSoC clock, sending each bit to the UART as
// 'H'/'L' with a newline every MAX_COL characters and after the last bit.
// Ports:
//   clk, rstn                    system clock, synchronous active-low reset
//   start_i, soc_rst_i,
//   run_ticks_i                  dump request and its options (sampled together)
//   abort_i                      terminate a running dump
//   busy_o, done_o               status to the command parser
//   tx_start_o, tx_data_o,
//   tx_ready_i                   UART transmit handshake
//   csoc_clk, csoc_rstn,
//   csoc_test_tm, csoc_test_se   CSoC clock/reset/test pins
//   csoc_scan_i                  CSoC scan-chain output
//
// state       | meaning
// ------------+------------------------------------------------
// IDLE        | waiting for start_i, CSoC out of reset
// SOC_RST     | csoc_rstn held low for RST_TICKS cycles
// RUN_HI      | functional clock high
// RUN_LO      | functional clock low, count down run ticks
// SEND        | scan bit as 'H'/'L' offered to the UART
// WAIT        | gap cycle after the UART took the byte
// SHIFT_HI    | scan clock high
// SHIFT_LO    | scan clock low, advance bit/column counters
// EOL         | newline offered to the UART
// EOL_WAIT    | gap cycle after the newline
// DONE        | one-cycle completion pulse
module scan_dump_ctrl
    import csoc_dbg_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int MAX_COL   = DEF_MAX_COL,
    parameter int RST_TICKS = DEF_RST_TICKS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        soc_rst_i,
    input  logic [15:0] run_ticks_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        csoc_clk,
    output logic        csoc_rstn,
    output logic        csoc_test_tm,
    output logic        csoc_test_se,
    input  logic        csoc_scan_i
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int CW = $clog2(MAX_COL + 1);
    localparam int RW = (RST_TICKS > 1) ? $clog2(RST_TICKS) : 1;
    localparam logic [BW-1:0] LP_CHAIN    = BW'(CHAIN_LEN);
    localparam logic [CW-1:0] LP_COL      = CW'(MAX_COL);
    localparam logic [RW-1:0] LP_RST_LAST = RW'(RST_TICKS - 1);

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_ticks;
    logic [RW-1:0]   r_rst_cnt;
    logic [BW-1:0]   r_bit_cnt, w_bit_inc;
    logic [CW-1:0]   r_col_cnt, w_col_inc;

    logic r_busy, r_done, r_csoc_clk, r_csoc_rstn, r_tm, r_se;
    logic w_busy, w_done, w_csoc_clk, w_csoc_rstn, w_tm, w_se;

    logic       w_accept, w_load, w_clear;
    logic [7:0] w_tx_byte;

    assign w_bit_inc = r_bit_cnt + 1'b1;
    assign w_col_inc = r_col_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_ticks     <= 16'd0;
            r_rst_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_col_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_csoc_clk  <= 1'b0;
            r_csoc_rstn <= 1'b0;
            r_tm        <= 1'b0;
            r_se        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_csoc_clk  <= w_csoc_clk;
            r_csoc_rstn <= w_csoc_rstn;
            r_tm        <= w_tm;
            r_se        <= w_se;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_ticks   <= run_ticks_i;
                        r_bit_cnt <= '0;
                        r_col_cnt <= '0;
                        r_rst_cnt <= LP_RST_LAST;
                    end
                end
                ST_SOC_RST: begin
                    if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - 1'b1;
                end
                ST_RUN_LO: r_ticks <= r_ticks - 16'd1;
                ST_SHIFT_LO: begin
                    r_bit_cnt <= w_bit_inc;
                    r_col_cnt <= (w_col_inc == LP_COL) ? '0 : w_col_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (soc_rst_i)                w_state_nxt = ST_SOC_RST;
                    else if (run_ticks_i == 16'd0) w_state_nxt = ST_SEND;
                    else                          w_state_nxt = ST_RUN_HI;
                end
            end
            ST_SOC_RST: begin
                if (r_rst_cnt == '0)
                    w_state_nxt = (r_ticks == 16'd0) ? ST_SEND : ST_RUN_HI;
            end
            ST_RUN_HI:   w_state_nxt = ST_RUN_LO;
            // r_ticks is at least 1 here; the last tick goes straight to the dump
            ST_RUN_LO:   w_state_nxt = (r_ticks == 16'd1) ? ST_SEND : ST_RUN_HI;
            ST_SEND:     if (w_accept) w_state_nxt = ST_WAIT;
            ST_WAIT:     w_state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: w_state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: begin
                if (w_col_inc == LP_COL)       w_state_nxt = ST_EOL;
                else if (w_bit_inc < LP_CHAIN) w_state_nxt = ST_SEND;
                else                           w_state_nxt = ST_EOL;
            end
            ST_EOL:      if (w_accept) w_state_nxt = ST_EOL_WAIT;
            ST_EOL_WAIT: w_state_nxt = (r_bit_cnt < LP_CHAIN) ? ST_SEND : ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
        if (abort_i && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;

        // Output registers are loaded from the next state so every pin
        // changes on the same edge as the state it belongs to.
        w_busy      = (w_state_nxt != ST_IDLE);
        w_done      = (w_state_nxt == ST_DONE);
        w_csoc_clk  = (w_state_nxt inside {ST_RUN_HI, ST_SHIFT_HI});
        w_csoc_rstn = (w_state_nxt != ST_SOC_RST);
        w_tm        = (w_state_nxt inside {ST_RUN_HI, ST_RUN_LO, ST_SEND, ST_WAIT,
                                           ST_SHIFT_HI, ST_SHIFT_LO, ST_EOL, ST_EOL_WAIT});
        w_se        = (w_state_nxt inside {ST_SEND, ST_WAIT, ST_SHIFT_HI, ST_SHIFT_LO,
                                           ST_EOL, ST_EOL_WAIT});

        w_load    = (w_state_nxt != r_state) &&
                    ((w_state_nxt == ST_SEND) || (w_state_nxt == ST_EOL));
        w_tx_byte = (w_state_nxt == ST_EOL) ? CH_NL : scan_char(csoc_scan_i);
        w_clear   = (w_state_nxt == ST_IDLE);
    end

    uart_tx_req u_tx_req (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_load),
        .i_data     (w_tx_byte),
        .i_clear    (w_clear),
        .tx_ready_i (tx_ready_i),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .o_accept   (w_accept)
    );

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign csoc_clk     = r_csoc_clk;
    assign csoc_rstn    = r_csoc_rstn;
    assign csoc_test_tm = r_tm;
    assign csoc_test_se = r_se;

endmodule

// File: tb/tb_scan_dump_ctrl.sv
module tb_scan_dump_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, soc_rst = 1'b0, abort = 1'b0;
    logic [15:0] ticks = 16'd0;
    logic        busy, done, tx_start, tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        cclk, crstn, tm, se, scan = 1'b1;

    logic        start16 = 1'b0;
    logic [15:0] ticks16 = 16'd0;
    logic        busy16, done16, txs16, cclk16, crst16, tm16, se16;
    logic [7:0]  txd16;

    int total = 0;
    int bad   = 0;

    // bench-side monitors
    logic [7:0] q[$];
    logic [7:0] q16[$];
    int bp_len = 0, bp_cnt = 0;
    int sidx = 0, run_pulses = 0, scan_pulses = 0, dbl_high = 0;
    int clk_pending = 0, done_cnt = 0, rstn_low = 0, done16_cnt = 0;
    logic prev_clk = 1'b0;

    always #5 clk = ~clk;

    scan_dump_ctrl #(.CHAIN_LEN(20), .MAX_COL(8), .RST_TICKS(4)) u_dut (
        .clk(clk), .rstn(rstn), .start_i(start), .soc_rst_i(soc_rst),
        .run_ticks_i(ticks), .abort_i(abort), .busy_o(busy), .done_o(done),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
        .csoc_clk(cclk), .csoc_rstn(crstn), .csoc_test_tm(tm),
        .csoc_test_se(se), .csoc_scan_i(scan)
    );

    scan_dump_ctrl #(.CHAIN_LEN(16), .MAX_COL(8), .RST_TICKS(4)) u_dut16 (
        .clk(clk), .rstn(rstn), .start_i(start16), .soc_rst_i(1'b0),
        .run_ticks_i(ticks16), .abort_i(1'b0), .busy_o(busy16), .done_o(done16),
        .tx_start_o(txs16), .tx_data_o(txd16), .tx_ready_i(1'b1),
        .csoc_clk(cclk16), .csoc_rstn(crst16), .csoc_test_tm(tm16),
        .csoc_test_se(se16), .csoc_scan_i(1'b0)
    );

    // UART model, CSoC scan-chain model (alternating from 1) and event counters
    always @(negedge clk) begin
        if (bp_cnt > 0) begin
            tx_ready = 1'b0;
            bp_cnt = bp_cnt - 1;
        end else begin
            tx_ready = 1'b1;
        end
        if (tx_start && tx_ready) begin
            q.push_back(tx_data);
            bp_cnt = bp_len;
        end
        if (cclk && !prev_clk) begin
            if (se) begin
                scan_pulses = scan_pulses + 1;
                sidx = sidx + 1;
            end else begin
                run_pulses = run_pulses + 1;
            end
        end
        if (cclk && prev_clk) dbl_high = dbl_high + 1;
        prev_clk = cclk;
        if (cclk && tx_start) clk_pending = clk_pending + 1;
        if (done) done_cnt = done_cnt + 1;
        if (!crstn && rstn) rstn_low = rstn_low + 1;
        scan = (sidx % 2 == 0);
        if (txs16) q16.push_back(txd16);
        if (done16) done16_cnt = done16_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q.delete();
        q16.delete();
        sidx = 0; scan = 1'b1;
        run_pulses = 0; scan_pulses = 0; dbl_high = 0;
        clk_pending = 0; done_cnt = 0; rstn_low = 0; done16_cnt = 0;
    endtask

    task automatic pulse_start(input logic r, input logic [15:0] t);
        start = 1'b1; soc_rst = r; ticks = t;
        step();
        start = 1'b0; soc_rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        step();
    endtask

    task automatic check_bytes(input string tag, input string exp);
        chk({tag, "_len"}, q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            if (i < q.size())
                chk($sformatf("%s[%0d]", tag, i), {24'd0, q[i]}, {24'd0, exp[i]});
    endtask

    localparam string EXP20 = "HLHLHLHL\nHLHLHLHL\nHLHL\n";

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) step();
        chk("rst_tx_start", {31'd0, tx_start}, 0);
        chk("rst_tx_data",  {24'd0, tx_data}, 0);
        chk("rst_cclk",     {31'd0, cclk}, 0);
        chk("rst_crstn",    {31'd0, crstn}, 0);
        chk("rst_tm",       {31'd0, tm}, 0);
        chk("rst_se",       {31'd0, se}, 0);
        chk("rst_busy",     {31'd0, busy}, 0);
        chk("rst_done",     {31'd0, done}, 0);
        rstn = 1'b1;
        step();
        chk("idle_crstn", {31'd0, crstn}, 1);
        clear_mon();

        // run 6 ticks, then dump 20 alternating bits
        pulse_start(1'b0, 16'd6);
        chk("t1_first_rise", {31'd0, cclk}, 1);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_tm", {31'd0, tm}, 1);
        chk("t1_se", {31'd0, se}, 0);
        wait_idle("t1", 2000);
        chk("t1_run_pulses", run_pulses, 6);
        chk("t1_scan_pulses", scan_pulses, 20);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_dbl_high", dbl_high, 0);
        check_bytes("t1", EXP20);

        // CHAIN_LEN multiple of MAX_COL: single final newline
        clear_mon();
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        for (int n = 0; n < 2000 && busy16 === 1'b1; n++) step();
        chk("t2_idle", {31'd0, busy16}, 0);
        step();
        chk("t2_done_cnt", done16_cnt, 1);
        chk("t2_len", q16.size(), 18);
        for (int i = 0; i < 18 && i < q16.size(); i++)
            chk($sformatf("t2[%0d]", i), {24'd0, q16[i]},
                (i == 8 || i == 17) ? 32'h0A : 32'h4C);

        // CSoC reset with zero run ticks
        clear_mon();
        pulse_start(1'b1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rstn_low%0d", i), {31'd0, crstn}, 0);
            step();
        end
        chk("t3_rstn_back", {31'd0, crstn}, 1);
        chk("t3_send_next", {31'd0, tx_start}, 1);
        wait_idle("t3", 2000);
        chk("t3_rstn_low_cnt", rstn_low, 4);
        chk("t3_run_pulses", run_pulses, 0);
        check_bytes("t3", EXP20);

        // UART back-pressure
        clear_mon();
        bp_len = 100;
        pulse_start(1'b0, 16'd2);
        wait_idle("t4", 5000);
        bp_len = 0;
        chk("t4_clk_pending", clk_pending, 0);
        chk("t4_run_pulses", run_pulses, 2);
        chk("t4_done_cnt", done_cnt, 1);
        check_bytes("t4", EXP20);

        // abort during the shift of bit 5, then restart
        clear_mon();
        pulse_start(1'b0, 16'd0);
        begin
            int n = 0;
            int c = 0;
            while (n < 6 && c < 500) begin
                if (cclk && se) n++;
                if (n < 6) step();
                c++;
            end
            chk("t5_reach_bit5", n, 6);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_cclk", {31'd0, cclk}, 0);
        chk("t5_tm", {31'd0, tm}, 0);
        chk("t5_se", {31'd0, se}, 0);
        chk("t5_tx_start", {31'd0, tx_start}, 0);
        repeat (3) step();
        chk("t5_no_done", done_cnt, 0);
        check_bytes("t5", "HLHLHL");
        clear_mon();
        pulse_start(1'b0, 16'd0);
        wait_idle("t5r", 2000);
        chk("t5r_done_cnt", done_cnt, 1);
        check_bytes("t5r", EXP20);

        // rstn low during RUN, then start while busy is ignored
        clear_mon();
        pulse_start(1'b0, 16'd50);
        repeat (5) step();
        chk("t6_busy_run", {31'd0, busy}, 1);
        rstn = 1'b0;
        step();
        chk("t6_rst_cclk",  {31'd0, cclk}, 0);
        chk("t6_rst_crstn", {31'd0, crstn}, 0);
        chk("t6_rst_tm",    {31'd0, tm}, 0);
        chk("t6_rst_busy",  {31'd0, busy}, 0);
        chk("t6_rst_txs",   {31'd0, tx_start}, 0);
        chk("t6_rst_txd",   {24'd0, tx_data}, 0);
        rstn = 1'b1;
        step();
        chk("t6_idle_busy", {31'd0, busy}, 0);
        clear_mon();
        pulse_start(1'b0, 16'd3);
        step();
        pulse_start(1'b1, 16'd0);
        chk("t6_busy_kept", {31'd0, busy}, 1);
        wait_idle("t6", 2000);
        chk("t6_run_pulses", run_pulses, 3);
        chk("t6_no_rst", rstn_low, 0);
        check_bytes("t6", EXP20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_dump_ctrl.md
# scan_dump_ctrl

Sequencer that runs the CSoC under test for a programmable number of functional clocks, then shifts its scan chain out one bit per CSoC clock and streams each bit to the UART transmitter as ASCII 'H'/'L', with a newline every MAX_COL characters. It owns the CSoC clock, reset and test-mode pins and the UART transmit request. A command parser starts it and observes busy/done.

## Interface
- CHAIN_LEN, 1919: scan-chain length in flops
- MAX_COL, 8: characters per output line
- RST_TICKS, 4: clk cycles csoc_rstn is held low when a reset is requested
- clk  in  1  system clock
- rstn  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle request to begin a dump; ignored while busy_o=1
- soc_rst_i  in  1  sampled with start_i; 1 = reset CSoC before running
- run_ticks_i  in  16  functional CSoC clocks before the dump; sampled with start_i
- abort_i  in  1  terminate the current operation
- busy_o  out  1  high from the cycle after accepted start_i until return to IDLE
- done_o  out  1  one-cycle pulse when the final newline is accepted
- tx_start_o  out  1  byte request to the UART transmitter
- tx_data_o  out  8  byte to transmit, valid while tx_start_o=1
- tx_ready_i  in  1  transmitter idle; a byte is accepted on any cycle with tx_start_o & tx_ready_i
- csoc_clk  out  1  CSoC clock
- csoc_rstn  out  1  CSoC reset, active low
- csoc_test_tm  out  1  CSoC test mode
- csoc_test_se  out  1  CSoC scan enable
- csoc_scan_i  in  1  CSoC scan-chain output (csoc_data_i[7] at the top level)

## Operation
- All outputs registered. Reset values: tx_start_o=0, tx_data_o=0x00, csoc_clk=0, csoc_rstn=0, csoc_test_tm=0, csoc_test_se=0, busy_o=0, done_o=0. IDLE drives csoc_rstn=1.
- States: IDLE, SOC_RST, RUN_HI, RUN_LO, SEND, WAIT, SHIFT_HI, SHIFT_LO, EOL, EOL_WAIT, DONE.
- IDLE: on start_i, latch run_ticks_i and clear bit_cnt and col_cnt. Go to SOC_RST if soc_rst_i, else RUN_HI. If the latched run_ticks is 0, skip directly to SEND.
- SOC_RST: csoc_rstn=0 for RST_TICKS cycles, then RUN_HI (or SEND if ticks=0).
- RUN_HI/RUN_LO: csoc_clk=1 for one cycle, then 0 for one cycle; tm=1, se=0. Decrement ticks after RUN_LO; at 0 go to SEND.
- SEND: tm=1, se=1. tx_data_o = csoc_scan_i ? 0x48 'H' : 0x4C 'L', sampled on entry. Hold tx_start_o until accepted, then WAIT.
- WAIT: one cycle with tx_start_o=0, because the transmitter drops tx_ready_i the cycle after acceptance. Then SHIFT_HI (csoc_clk=1), then SHIFT_LO (csoc_clk=0). Then bit_cnt+1 and col_cnt+1.
- After SHIFT_LO:
  - col_cnt==MAX_COL: go to EOL, send 0x0A, reset col_cnt to 0.
  - Else, bit_cnt<CHAIN_LEN: go to SEND.
  - Else: go to EOL (final newline).
- After EOL_WAIT: go to SEND if bits remain, else DONE. The final newline is not duplicated when CHAIN_LEN is a multiple of MAX_COL.
- DONE: done_o=1 for one cycle, tm=0, se=0, then IDLE.
- abort_i (any non-IDLE state): next cycle is IDLE, with tx_start_o=0, csoc_clk=0, tm=se=0, and no done_o. A byte already accepted by the transmitter still completes.
- abort_i and start_i together in IDLE: start wins; abort only acts on a busy block.

## Timing
- Start to first csoc_clk rise (no reset): 1 cycle.
- Functional run phase: exactly 2·run_ticks clk cycles.
- Per scan bit: ≥4 cycles (SEND acceptance, WAIT, SHIFT_HI, SHIFT_LO), plus UART back-pressure.
- csoc_clk never high for two consecutive cycles.
- csoc_scan_i is sampled at least one cycle after the preceding falling csoc_clk.
- Bytes per dump: CHAIN_LEN + ceil(CHAIN_LEN/MAX_COL).
- Counter widths: $clog2(CHAIN_LEN+1) for bit_cnt, $clog2(MAX_COL+1) for col_cnt.
- rstn low mid-dump: all outputs return to reset values at the next clk edge, and the FSM returns to IDLE.

## Structure
- Shared package csoc_dbg_pkg holds:
  - state enum
  - ASCII constants: CH_H=0x48, CH_L=0x4C, CH_NL=0x0A
  - default CHAIN_LEN/MAX_COL
- One sub-module, uart_tx_req: holds tx_start_o/tx_data_o until tx_ready_i, then reports an accept pulse and enforces the one-cycle WAIT gap. It is reused by the command parser's response path.

## Test plan
- CHAIN_LEN=20, MAX_COL=8, run_ticks=6, scan pattern alternating from 1, tx_ready_i always 1 -> 6 csoc_clk pulses with se=0, then bytes "HLHLHLHL\nHLHLHLHL\nHLHL\n" (23 bytes), done_o once.
- CHAIN_LEN=16, MAX_COL=8, all zeros -> "LLLLLLLL\nLLLLLLLL\n" (18 bytes), no duplicate newline.
- soc_rst_i=1, run_ticks=0 -> csoc_rstn low exactly 4 cycles, no run pulses, first SEND directly after.
- UART back-pressure: tx_ready_i low for 100 cycles per byte -> no csoc_clk pulse while a byte is pending, and byte order unchanged.
- abort_i asserted mid-shift at bit 5 -> IDLE next cycle, csoc_clk=0, no done_o. A new start_i then restarts with bit_cnt=0.
- rstn low during RUN -> all outputs at reset values next edge; start_i while busy is ignored (busy_o unchanged).
